// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI bridge: FSM encodings,
// default transaction IDs and the fixed single-beat AXI attributes.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    localparam logic [3:0] DEF_INST_ID    = 4'd0;
    localparam logic [3:0] DEF_DATA_ID    = 4'd1;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // SRAM size codes 0/1/2 map directly onto AXI byte/half/word sizes.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI master.
// One outstanding transaction per port; data reads win arbitration and wait out stores.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = DEF_INST_ID,
    parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e   r_rstate, w_rstate_nxt;
    wr_state_e   r_wstate, w_wstate_nxt;
    logic        r_inst_busy, r_data_busy;
    logic        r_aw_done, r_w_done;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [1:0]  r_arsize;
    logic [31:0] r_awaddr;
    logic [1:0]  r_awsize;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;

    logic w_data_rd_ok, w_data_wr_ok, w_inst_ok, w_rd_accept;
    logic w_ar_fire, w_r_fire, w_aw_fire, w_w_fire, w_b_fire, w_aw_w_done;
    logic w_unused_inputs;

    // Arbitration: a data read needs both FSMs idle, so it never overtakes a store.
    assign w_data_rd_ok = resetn & data_sram_req & ~data_sram_wr & (r_rstate == R_IDLE)
                        & (r_wstate == W_IDLE) & ~r_data_busy;
    assign w_data_wr_ok = resetn & data_sram_req & data_sram_wr & (r_wstate == W_IDLE)
                        & ~r_data_busy;
    assign w_inst_ok    = resetn & inst_sram_req & (r_rstate == R_IDLE) & ~r_inst_busy
                        & ~w_data_rd_ok;
    assign w_rd_accept  = w_data_rd_ok | w_inst_ok;

    assign inst_sram_addr_ok = w_inst_ok;
    assign data_sram_addr_ok = w_data_rd_ok | w_data_wr_ok;

    assign w_ar_fire   = arvalid & arready;
    assign w_r_fire    = rvalid & rready;
    assign w_aw_fire   = awvalid & awready;
    assign w_w_fire    = wvalid & wready;
    assign w_b_fire    = bvalid & bready;
    assign w_aw_w_done = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);

    assign inst_sram_data_ok = w_r_fire & (rid == INST_ID);
    assign data_sram_data_ok = (w_r_fire & (rid == DATA_ID)) | w_b_fire;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it held (no latch).
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rd_accept) w_rstate_nxt = R_AR;
            R_AR:    if (w_ar_fire)   w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_fire)    w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_data_wr_ok) w_wstate_nxt = W_REQ;
            W_REQ:   if (w_aw_w_done)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_fire)     w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (r_rstate == R_AR);
        rready  = (r_rstate == R_DATA);
        awvalid = (r_wstate == W_REQ) & ~r_aw_done;
        wvalid  = (r_wstate == W_REQ) & ~r_w_done;
        bready  = (r_wstate == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_inst_busy <= 1'b0;
            r_data_busy <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            if (w_inst_ok)              r_inst_busy <= 1'b1;
            else if (inst_sram_data_ok) r_inst_busy <= 1'b0;
            if (data_sram_addr_ok)      r_data_busy <= 1'b1;
            else if (data_sram_data_ok) r_data_busy <= 1'b0;
            if (r_wstate != W_REQ) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
        end
    end

    // NOTE: request payload registers carry no reset; they are only observed while a valid is high.
    always_ff @(posedge clk) begin
        if (w_rd_accept) begin
            r_arid   <= w_data_rd_ok ? DATA_ID : INST_ID;
            r_araddr <= w_data_rd_ok ? data_sram_addr : inst_sram_addr;
            r_arsize <= w_data_rd_ok ? data_sram_size : inst_sram_size;
        end
        if (w_data_wr_ok) begin
            r_awaddr <= data_sram_addr;
            r_awsize <= data_sram_size;
            r_wstrb  <= data_sram_wstrb;
            r_wdata  <= data_sram_wdata;
        end
    end

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arsize  = axi_size(r_arsize);
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = DATA_ID;
    assign awaddr  = r_awaddr;
    assign awsize  = axi_size(r_awsize);
    assign awlen   = AXI_LEN_SINGLE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid   = DATA_ID;
    assign wdata = r_wdata;
    assign wstrb = r_wstrb;
    assign wlast = 1'b1;

    // Fetch-side write fields and AXI response codes have no consumer.
    assign w_unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                               rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: a cycle-based AXI slave model with
// programmable stalls, and scoreboard queues filled at acceptance and drained on data_ok.
module tb_sram_axi_bridge;
    import sram_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct { logic is_store; logic [31:0] data; } dexp_t;
    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; int cyc; } ar_rec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int inst_dok_cyc = -1;
    int data_dok_cyc = -1;
    int b_cyc = -1;
    int ar_stall = 0, r_stall = 0, aw_stall = 0, w_stall = 0, b_stall = 0;

    logic [31:0] inst_exp_q[$];
    dexp_t       data_exp_q[$];
    ar_rec_t     ar_log[$];
    logic [31:0] slv_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : def_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
    endfunction

    // Response monitor: scoreboard entries are consumed on each data_ok pulse.
    initial begin : monitor
        logic [31:0] e;
        dexp_t d;
        forever begin
            @(negedge clk);
            if (inst_sram_data_ok) begin
                inst_dok_cyc = cyc;
                if (inst_exp_q.size() == 0) check("inst_dok_spurious", inst_sram_data_ok, 1'b0);
                else begin
                    e = inst_exp_q.pop_front();
                    check("inst_rdata", inst_sram_rdata, e);
                end
            end
            if (data_sram_data_ok) begin
                data_dok_cyc = cyc;
                if (data_exp_q.size() == 0) check("data_dok_spurious", data_sram_data_ok, 1'b0);
                else begin
                    d = data_exp_q.pop_front();
                    if (d.is_store) check("store_dok_on_b", bvalid, 1'b1);
                    else            check("load_rdata", data_sram_rdata, d.data);
                end
            end
        end
    end

    // AXI slave: acts once per cycle just after the clock edge.
    initial begin : slave
        ar_rec_t     rq[$];
        ar_rec_t     ar_cap;
        logic        ar_f, r_f, aw_f, w_f, b_f, aw_got, w_got;
        logic [31:0] cap_awaddr, cap_wdata;
        logic [3:0]  cap_wstrb;
        int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        {ar_f, r_f, aw_f, w_f, b_f, aw_got, w_got} = '0;
        {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
        {arready, rvalid, awready, wready, bvalid} = '0;
        rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; bid = 4'd1; bresp = 2'd0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                rq.delete();
                {ar_f, r_f, aw_f, w_f, b_f, aw_got, w_got} = '0;
                {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
                {arready, rvalid, awready, wready, bvalid} = '0;
            end else begin
                if (ar_f) begin ar_log.push_back(ar_cap); rq.push_back(ar_cap); end
                if (r_f) begin rvalid = 1'b0; rq.delete(0); end
                if (aw_f) aw_got = 1'b1;
                if (w_f)  w_got  = 1'b1;
                if (b_f)  bvalid = 1'b0;

                arready = 1'b0;
                if (arvalid) begin
                    if (ar_cnt >= ar_stall) arready = 1'b1;
                    else ar_cnt++;
                end
                if (!rvalid && rq.size() != 0) begin
                    if (r_cnt >= r_stall) begin
                        rvalid = 1'b1; rid = rq[0].id; rdata = slv_rd(rq[0].addr); r_cnt = 0;
                    end else r_cnt++;
                end
                awready = 1'b0;
                if (awvalid) begin
                    if (aw_cnt >= aw_stall) awready = 1'b1;
                    else aw_cnt++;
                end
                wready = 1'b0;
                if (wvalid) begin
                    if (w_cnt >= w_stall) wready = 1'b1;
                    else w_cnt++;
                end
                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_stall) begin
                        bvalid = 1'b1; b_cnt = 0; aw_got = 1'b0; w_got = 1'b0;
                        slv_mem[cap_awaddr] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);
                    end else b_cnt++;
                end

                ar_f = arvalid && arready;
                if (ar_f) begin
                    ar_cap = '{id: arid, addr: araddr, size: arsize, cyc: cyc};
                    ar_cnt = 0;
                end
                r_f  = rvalid && rready;
                aw_f = awvalid && awready;
                if (aw_f) begin cap_awaddr = awaddr; aw_cnt = 0; end
                w_f  = wvalid && wready;
                if (w_f) begin cap_wdata = wdata; cap_wstrb = wstrb; w_cnt = 0; end
                b_f  = bvalid && bready;
                if (b_f) b_cyc = cyc;
            end
        end
    end

    task automatic inst_fetch(input logic [31:0] a, output int acc);
        int n;
        @(posedge clk); #1;
        inst_sram_req = 1'b1; inst_sram_addr = a; inst_sram_size = 2'd2;
        acc = -1; n = 0;
        while (acc < 0 && n < 100) begin
            @(negedge clk);
            if (inst_sram_addr_ok) begin acc = cyc; inst_exp_q.push_back(ref_rd(a)); end
            n++;
        end
        if (acc < 0) check("inst_accept_timeout", inst_sram_addr_ok, 1'b1);
        @(posedge clk); #1;
        inst_sram_req = 1'b0;
    endtask

    task automatic data_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] strb, output int acc);
        int n;
        @(posedge clk); #1;
        data_sram_req = 1'b1; data_sram_wr = wr; data_sram_addr = a;
        data_sram_wdata = wd; data_sram_wstrb = strb; data_sram_size = 2'd2;
        acc = -1; n = 0;
        while (acc < 0 && n < 100) begin
            @(negedge clk);
            if (data_sram_addr_ok) begin
                acc = cyc;
                if (wr) begin
                    ref_mem[a] = merge(ref_rd(a), wd, strb);
                    data_exp_q.push_back('{is_store: 1'b1, data: 32'd0});
                end else data_exp_q.push_back('{is_store: 1'b0, data: ref_rd(a)});
            end
            n++;
        end
        if (acc < 0) check("data_accept_timeout", data_sram_addr_ok, 1'b1);
        @(posedge clk); #1;
        data_sram_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((inst_exp_q.size() != 0 || data_exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(inst_exp_q.size() + data_exp_q.size()), 32'd0);
    endtask

    task automatic check_all_idle(input string tag);
        check(tag, {arvalid, rready, awvalid, wvalid, bready, inst_sram_addr_ok,
                    data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acc, dacc, iacc, n0, n;
        logic [3:0] exp_aw, exp_w, exp_b;
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        slv_mem[32'h1c00_0000] = 32'h0280_0c0c; ref_mem[32'h1c00_0000] = 32'h0280_0c0c;
        slv_mem[32'h1c00_8000] = 32'h1122_3344; ref_mem[32'h1c00_8000] = 32'h1122_3344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_idle("reset_outputs");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single fetch at minimum latency.
        inst_fetch(32'h1c00_0000, acc);
        wait_drain("fetch_drain");
        check("fetch_arid", ar_log[ar_log.size()-1].id, 4'd0);
        check("fetch_araddr", ar_log[ar_log.size()-1].addr, 32'h1c00_0000);
        check("fetch_arsize", ar_log[ar_log.size()-1].size, 3'd2);
        check("fetch_ar_cycle", ar_log[ar_log.size()-1].cyc, acc + 1);
        check("fetch_dok_cycle", inst_dok_cyc, acc + 2);

        // Simultaneous data read and fetch: data wins, fetch follows the data R.
        n0 = ar_log.size();
        fork
            data_access(1'b0, 32'h1c00_0100, 32'd0, 4'd0, dacc);
            inst_fetch(32'h1c00_0200, iacc);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                check("tie_data_addr_ok", data_sram_addr_ok, 1'b1);
                check("tie_inst_addr_ok", inst_sram_addr_ok, 1'b0);
            end
        join
        wait_drain("tie_drain");
        check("tie_first_arid", ar_log[n0].id, 4'd1);
        check("tie_second_arid", ar_log[n0+1].id, 4'd0);
        check("tie_inst_after_data", iacc, data_dok_cyc + 1);

        // Store with AW accepted two cycles before W.
        aw_stall = 0; w_stall = 2; b_stall = 0;
        exp_aw = 4'b0001; exp_w = 4'b0111; exp_b = 4'b1000;
        data_access(1'b1, 32'h1c00_8000, 32'hdead_beef, 4'b0011, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("st_awvalid", awvalid, exp_aw[i]);
            check("st_wvalid", wvalid, exp_w[i]);
            check("st_bready", bready, exp_b[i]);
        end
        wait_drain("store_drain");
        check("store_b_cycle", b_cyc, acc + 4);
        check("store_dok_cycle", data_dok_cyc, b_cyc);

        // Load behind a store whose B is delayed.
        w_stall = 0; b_stall = 4;
        data_access(1'b1, 32'h1c00_8004, 32'hcafe_f00d, 4'b1111, acc);
        data_access(1'b0, 32'h1c00_8000, 32'd0, 4'd0, dacc);
        check("raw_load_after_b", dacc, b_cyc + 1);
        b_stall = 0;
        data_access(1'b0, 32'h1c00_8004, 32'd0, 4'd0, dacc);
        wait_drain("raw_drain");

        // AR stalled for five cycles with competing requests on both ports.
        ar_stall = 5;
        inst_fetch(32'h1c00_0300, acc);
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0400;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1c00_0500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_arvalid", arvalid, 1'b1);
            check("stall_araddr", araddr, 32'h1c00_0300);
            check("stall_arid", arid, 4'd0);
            check("stall_inst_addr_ok", inst_sram_addr_ok, 1'b0);
            check("stall_data_addr_ok", data_sram_addr_ok, 1'b0);
        end
        @(posedge clk); #1;
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        wait_drain("stall_drain");
        ar_stall = 0;

        // Reset while the read FSM waits for R.
        r_stall = 3;
        inst_fetch(32'h1c00_0000, acc);
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); n++; end
        check("rst_reached_rdata", rready, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_idle("rst_midread_outputs");
        inst_exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        r_stall = 0;
        inst_fetch(32'h1c00_0000, acc);
        wait_drain("post_rst_drain");
        check("post_rst_dok_cycle", inst_dok_cyc, acc + 2);
        check("post_rst_araddr", ar_log[ar_log.size()-1].addr, 32'h1c00_0000);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
